// File: rtl/solar_pkg.sv
// Shared types and constants for the solar tracker stepper driver.
package solar_pkg;

    localparam int unsigned DIV_W   = 16;
    localparam int unsigned POS_W   = 8;
    localparam int unsigned PHASE_W = 4;
    localparam int unsigned IDX_W   = 2;

    localparam logic [DIV_W-1:0]   STEP_DIV_DEF = 16'd1000;
    localparam logic [POS_W-1:0]   POS_MAX_DEF  = 8'd200;
    localparam logic [POS_W-1:0]   HOME_DEF     = 8'd100;

    localparam logic [PHASE_W-1:0] PHASE_OFF  = 4'b0000;
    localparam logic [PHASE_W-1:0] PHASE_HOME = 4'b1100;

    // Per-axis motion state.
    typedef enum logic [1:0] {
        AX_IDLE = 2'd0,
        AX_FWD  = 2'd1,
        AX_REV  = 2'd2,
        AX_LIM  = 2'd3
    } axis_state_e;

    // Registered copy of the tracker's motor command lines.
    typedef struct packed {
        logic n;
        logic e;
        logic s;
        logic w;
    } motor_cmd_t;

    // Two-phase-on full-step coil pattern for a phase index.
    function automatic logic [PHASE_W-1:0] phase_decode(input logic [IDX_W-1:0] idx);
        logic [PHASE_W-1:0] pat;
        pat = PHASE_HOME;
        case (idx)
            2'd0:    pat = 4'b1100;
            2'd1:    pat = 4'b0110;
            2'd2:    pat = 4'b0011;
            default: pat = 4'b1001;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/solar_axis.sv
// One stepper axis: IDLE/FWD/REV/LIM state, soft-limited position and
// phase index. Coil drive in IDLE/LIM is held when SOLAR_DRV_HOLD_EN is
// defined, otherwise released to 4'b0000.
module solar_axis
    import solar_pkg::*;
#(
    parameter logic [POS_W-1:0] POS_MAX = POS_MAX_DEF,
    parameter logic [POS_W-1:0] HOME    = HOME_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_i,
    input  logic               fwd_i,
    input  logic               rev_i,
    output logic [PHASE_W-1:0] phase_o,
    output logic [POS_W-1:0]   pos_o,
    output logic               busy_o,
    output logic               lim_o
);

`ifdef SOLAR_DRV_HOLD_EN
    localparam logic [PHASE_W-1:0] PHASE_RST = PHASE_HOME;
`else
    localparam logic [PHASE_W-1:0] PHASE_RST = PHASE_OFF;
`endif

    axis_state_e        state_q, state_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               lim_fwd_q, lim_fwd_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               busy_q, busy_d;
    logic               lim_q, lim_d;
    logic               fwd_only;
    logic               rev_only;
    logic               drive;

    assign fwd_only = fwd_i & ~rev_i;
    assign rev_only = rev_i & ~fwd_i;

    // Next-state, position and phase decisions, taken only on a step tick.
    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        idx_d     = idx_q;
        lim_fwd_d = lim_fwd_q;
        if (tick_i) begin
            case (state_q)
                AX_IDLE: begin
                    if (fwd_only) begin
                        state_d = AX_FWD;
                    end else if (rev_only) begin
                        state_d = AX_REV;
                    end
                end
                AX_FWD: begin
                    if (!fwd_only) begin
                        state_d = AX_IDLE;
                    end else if (pos_q < POS_MAX) begin
                        pos_d = pos_q + 8'd1;
                        idx_d = idx_q + 2'd1;
                    end else begin
                        state_d   = AX_LIM;
                        lim_fwd_d = 1'b1;
                    end
                end
                AX_REV: begin
                    if (!rev_only) begin
                        state_d = AX_IDLE;
                    end else if (pos_q != 8'd0) begin
                        pos_d = pos_q - 8'd1;
                        idx_d = idx_q - 2'd1;
                    end else begin
                        state_d   = AX_LIM;
                        lim_fwd_d = 1'b0;
                    end
                end
                AX_LIM: begin
                    // Stay only while the command that hit the limit persists.
                    if (lim_fwd_q ? !fwd_only : !rev_only) begin
                        state_d = AX_IDLE;
                    end
                end
                default: state_d = AX_IDLE;
            endcase
        end
        drive  = (state_d == AX_FWD) || (state_d == AX_REV);
        busy_d = drive;
        lim_d  = (state_d == AX_LIM);
`ifdef SOLAR_DRV_HOLD_EN
        phase_d = phase_decode(idx_d);
`else
        phase_d = drive ? phase_decode(idx_d) : PHASE_OFF;
`endif
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= AX_IDLE;
            pos_q     <= HOME;
            idx_q     <= '0;
            lim_fwd_q <= 1'b0;
            phase_q   <= PHASE_RST;
            busy_q    <= 1'b0;
            lim_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            idx_q     <= idx_d;
            lim_fwd_q <= lim_fwd_d;
            phase_q   <= phase_d;
            busy_q    <= busy_d;
            lim_q     <= lim_d;
        end
    end

    assign phase_o = phase_q;
    assign pos_o   = pos_q;
    assign busy_o  = busy_q;
    assign lim_o   = lim_q;

endmodule

// File: rtl/solar_motor_drv.sv
// Two-axis solar tracker stepper driver: command register, step prescaler
// and two solar_axis instances (NS, EW). Optional holding torque in IDLE/LIM
// is enabled by defining SOLAR_DRV_HOLD_EN.
module solar_motor_drv
    import solar_pkg::*;
#(
    parameter logic [DIV_W-1:0] STEP_DIV = STEP_DIV_DEF,
    parameter logic [POS_W-1:0] POS_MAX  = POS_MAX_DEF,
    parameter logic [POS_W-1:0] HOME     = HOME_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mn,
    input  logic               me,
    input  logic               ms,
    input  logic               mw,
    output logic [PHASE_W-1:0] ns_phase,
    output logic [PHASE_W-1:0] ew_phase,
    output logic [POS_W-1:0]   ns_pos,
    output logic [POS_W-1:0]   ew_pos,
    output logic               busy,
    output logic               lim_fault
);

    motor_cmd_t       cmd_q, cmd_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_c;
    logic             ns_busy, ew_busy;
    logic             ns_lim, ew_lim;

    assign tick_c = (cnt_q == (STEP_DIV - 16'd1));

    // Next command snapshot and prescaler count.
    always_comb begin
        cmd_d = {mn, me, ms, mw};
        cnt_d = tick_c ? '0 : cnt_q + 16'd1;
    end

    // Command register and prescaler with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cmd_q <= '0;
            cnt_q <= '0;
        end else begin
            cmd_q <= cmd_d;
            cnt_q <= cnt_d;
        end
    end

    solar_axis #(
        .POS_MAX (POS_MAX),
        .HOME    (HOME)
    ) u_ns (
        .clk     (clk),
        .rst     (rst),
        .tick_i  (tick_c),
        .fwd_i   (cmd_q.n),
        .rev_i   (cmd_q.s),
        .phase_o (ns_phase),
        .pos_o   (ns_pos),
        .busy_o  (ns_busy),
        .lim_o   (ns_lim)
    );

    solar_axis #(
        .POS_MAX (POS_MAX),
        .HOME    (HOME)
    ) u_ew (
        .clk     (clk),
        .rst     (rst),
        .tick_i  (tick_c),
        .fwd_i   (cmd_q.e),
        .rev_i   (cmd_q.w),
        .phase_o (ew_phase),
        .pos_o   (ew_pos),
        .busy_o  (ew_busy),
        .lim_o   (ew_lim)
    );

    assign busy      = ns_busy | ew_busy;
    assign lim_fault = ns_lim | ew_lim;

endmodule

// File: doc/solar_motor_drv.md
SOLAR_MOTOR_DRV -- requirements
Module: solar_motor_drv

Interface
REQ-001 SHALL have parameter STEP_DIV, default 16'd1000, clock cycles per motor step tick (legal range 2..65535).
REQ-002 SHALL have parameter POS_MAX, default 8'd200, upper soft limit of both axis position counters.
REQ-003 SHALL have parameter HOME, default 8'd100, position value loaded at reset (HOME <= POS_MAX).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports mn, me, ms, mw  input  1 each  one-hot motor commands from the solar tracker controller.
REQ-007 SHALL have port ns_phase  output  4  north/south stepper coil drive.
REQ-008 SHALL have port ew_phase  output  4  east/west stepper coil drive.
REQ-009 SHALL have ports ns_pos, ew_pos  output  8 each  current axis positions.
REQ-010 SHALL have port busy  output  1  high while either axis is in FWD or REV.
REQ-011 SHALL have port lim_fault  output  1  high while either axis is in LIM.

Function
REQ-012 SHALL register mn/me/ms/mw into a command register each cycle; all decisions use the registered copy (1-cycle input latency).
REQ-013 SHALL run a 16-bit prescaler counting 0..STEP_DIV-1, wrapping to 0, and assert a 1-cycle tick when the count equals STEP_DIV-1.
REQ-014 SHALL map the NS axis as fwd = mn, rev = ms, and the EW axis as fwd = me, rev = mw; the two axes operate independently and may move on the same tick.
REQ-015 SHALL implement, per axis, states IDLE, FWD, REV, LIM, with transitions evaluated only on tick.
REQ-016 IDLE: fwd-only -> FWD; rev-only -> REV; none or both -> stay IDLE; no step is taken on the entry tick.
REQ-017 FWD: fwd-only and pos < POS_MAX -> step (pos+1, phase index+1 mod 4); fwd-only and pos == POS_MAX -> LIM with no step; any other command -> IDLE.
REQ-018 REV: rev-only and pos > 0 -> step (pos-1, phase index-1 mod 4); rev-only and pos == 0 -> LIM with no step; any other command -> IDLE.
REQ-019 A direct reversal SHALL pass through IDLE, which guarantees at least one tick of dead time before the first opposite step.
REQ-020 LIM: remains while the command that caused it is held; any other command -> IDLE; position never leaves 0..POS_MAX.
REQ-021 SHALL decode phase index 0..3 to 4'b1100, 4'b0110, 4'b0011, 4'b1001 when the coil is driven.
REQ-022 Position and phase outputs SHALL update on the clock edge on which tick is high; busy and lim_fault SHALL be registered state decodes.

Reset
REQ-023 While rst is low at a clock edge: prescaler = 0, command register = 0, both axes IDLE, phase index = 0, ns_pos = ew_pos = HOME, busy = 0, lim_fault = 0.
REQ-024 Reset asserted mid-step SHALL abort motion immediately, with no partial update; the first tick after release occurs STEP_DIV cycles after release.

Configuration
REQ-025 With SOLAR_DRV_HOLD_EN defined, IDLE/LIM axes SHALL keep driving the current phase pattern (holding torque), and reset drives 4'b1100.
REQ-026 Without SOLAR_DRV_HOLD_EN, IDLE/LIM axes SHALL drive 4'b0000, and the pattern is driven only in FWD/REV (reset output 4'b0000).

Structure
REQ-027 SHALL place the axis state enum, the phase decode table and the default constants in shared package solar_pkg.
REQ-028 SHALL implement one axis (state machine, position, phase index) as sub-module solar_axis, instantiated twice; the prescaler and command register stay in the top level.

Verification
REQ-029 STEP_DIV=4, HOME=100, mn held 20 cycles -> ns_pos increments once per 4 cycles after the entry tick, ns_phase cycles 1100->0110->0011->1001, busy=1.
REQ-030 ns_pos=199, POS_MAX=200, mn held -> one step to 200, then LIM, lim_fault=1, no further steps; mn released -> IDLE on next tick, lim_fault=0.
REQ-031 mn then immediately ms -> at least one tick with no NS step, then ns_pos decrements.
REQ-032 me and mw both high -> EW stays IDLE, ew_pos unchanged; mn alone plus me alone simultaneously -> both axes step on the same tick.
REQ-033 rst low mid-run -> next edge: pos=HOME, busy=0, phase=1100 (HOLD_EN) or 0000 (no HOLD_EN).
REQ-034 Axis idle after steps -> phase holds last pattern with SOLAR_DRV_HOLD_EN, and reads 0000 without it.
